// File: rtl/tick_event_counter.sv
// ---------------------------------------------------------------------------
// tick_event_counter
//
// Purpose:
//   Counts rising edges of the prescaler's divided clock (tick_in) without
//   clocking anything from it. tick_in is synchronised into the clk_in domain
//   as plain data. A single-cycle tick is then derived from its rising edge.
//   The counter counts up or down, with compare match, auto-reload, one-shot
//   mode and modular wrap detection.
//
// Parameters:
//   WIDTH        width of count, load_value, compare and capture_value
//   SYNC_STAGES  synchroniser depth on tick_in (2..4)
//
// Ports:
//   clk_in         system clock
//   reset          asynchronous reset, active-low
//   tick_in        divided clock from the prescaler, asynchronous data
//   start          pulse: IDLE/DONE -> RUN
//   stop           pulse: RUN -> IDLE (wins over start)
//   load           pulse: count <= load_value (highest priority)
//   load_value     load and auto-reload value
//   compare        match value
//   dir            0 = count up, 1 = count down
//   oneshot        1 = park in DONE on match, 0 = auto-reload and keep running
//   count          current count (registered)
//   match          one-cycle pulse on compare hit (registered)
//   wrap           one-cycle pulse on modular wrap (registered)
//   running        high in RUN
//   done           high in DONE
//
// Optional feature (macro TICK_COUNTER_CAPTURE_EN):
//   capture        pulse: snapshot count into capture_value
//   capture_value  count as it stood before any same-cycle update
// ---------------------------------------------------------------------------
module tick_event_counter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] compare,
  input  logic             dir,
  input  logic             oneshot,
`ifdef TICK_COUNTER_CAPTURE_EN
  input  logic             capture,
  output logic [WIDTH-1:0] capture_value,
`endif
  output logic [WIDTH-1:0] count,
  output logic             match,
  output logic             wrap,
  output logic             running,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             edge_q;
  logic             tick;
  logic             step_tick;
  logic [WIDTH-1:0] next_val;
  logic             hit;
  logic             at_wrap;

  // Synchroniser chain plus one edge flop. Because tick_in is an unrelated
  // clock, only the last synchroniser stage is ever used by the logic below.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~edge_q;

  // A tick advances the counter only in RUN. Any load, stop or start in the
  // same cycle swallows it, so control pulses never race the arithmetic.
  assign step_tick = (state == RUN) && tick && !load && !stop && !start;

  assign next_val = dir ? (count - WIDTH'(1)) : (count + WIDTH'(1));
  assign hit      = (next_val == compare);
  assign at_wrap  = dir ? (count == '0) : (count == '1);

  // State register.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Load never moves the state by itself; stop beats start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && !stop) state_next = RUN;
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (step_tick && hit && oneshot) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start && !stop) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // State-decoded status outputs.
  always_comb begin
    running = (state == RUN);
    done    = (state == DONE);
  end

  // Count datapath. match and wrap default low so they pulse for exactly the
  // cycle whose count they describe. In auto-reload mode the reloaded value
  // replaces the matching value, but wrap still reports the step taken.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      count <= '0;
      match <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      match <= 1'b0;
      wrap  <= 1'b0;
      if (load) begin
        count <= load_value;
      end else if (step_tick) begin
        match <= hit;
        wrap  <= at_wrap;
        if (hit && !oneshot) begin
          count <= load_value;
        end else begin
          count <= next_val;
        end
      end
    end
  end

`ifdef TICK_COUNTER_CAPTURE_EN
  // Capture snapshots the pre-update count, so it is independent of any
  // load/tick landing on the same edge.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      capture_value <= '0;
    end else if (capture) begin
      capture_value <= count;
    end
  end
`endif

endmodule

// File: tb/tb_tick_event_counter.sv
// ---------------------------------------------------------------------------
// tb_tick_event_counter
//
// Table-driven bench for tick_event_counter. Each record drives one tick
// (or none) on tick_in plus optional control pulses timed to coincide with
// the synchronised tick. The expected outputs are pushed onto a scoreboard
// queue when the stimulus is driven. They are popped and compared once the
// DUT has updated. Multi-cycle corners (tick latency, stale edge at reset
// release, asynchronous reset, capture) are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_tick_event_counter;

  localparam int WIDTH       = 32;
  localparam int SYNC_STAGES = 2;

  logic             clk_in = 1'b0;
  logic             reset;
  logic             tick_in;
  logic             start;
  logic             stop;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] compare;
  logic             dir;
  logic             oneshot;
  logic [WIDTH-1:0] count;
  logic             match;
  logic             wrap;
  logic             running;
  logic             done;
`ifdef TICK_COUNTER_CAPTURE_EN
  logic             capture;
  logic [WIDTH-1:0] capture_value;
`endif

  typedef struct {
    logic        tk;
    logic        st;
    logic        sp;
    logic        ld;
    logic [31:0] lv;
    logic [31:0] cmp;
    logic        dr;
    logic        os;
    logic [31:0] e_count;
    logic        e_match;
    logic        e_wrap;
    logic        e_run;
    logic        e_done;
  } vec_t;

  typedef struct {
    logic [31:0] count;
    logic        match;
    logic        wrap;
    logic        run;
    logic        done;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  tick_event_counter #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .tick_in       (tick_in),
    .start         (start),
    .stop          (stop),
    .load          (load),
    .load_value    (load_value),
    .compare       (compare),
    .dir           (dir),
    .oneshot       (oneshot),
`ifdef TICK_COUNTER_CAPTURE_EN
    .capture       (capture),
    .capture_value (capture_value),
`endif
    .count         (count),
    .match         (match),
    .wrap          (wrap),
    .running       (running),
    .done          (done)
  );

  always #5 clk_in = ~clk_in;

  // Guards against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(input logic tk, st, sp, ld,
                              input logic [31:0] lv, cmp,
                              input logic dr, os,
                              input logic [31:0] ec,
                              input logic em, ew, er, ed);
    vec_t v;
    v.tk = tk; v.st = st; v.sp = sp; v.ld = ld;
    v.lv = lv; v.cmp = cmp; v.dr = dr; v.os = os;
    v.e_count = ec; v.e_match = em; v.e_wrap = ew; v.e_run = er; v.e_done = ed;
    return v;
  endfunction

  task automatic pushExp(input logic [31:0] c, input logic m, w, r, d);
    exp_t e;
    e.count = c; e.match = m; e.wrap = w; e.run = r; e.done = d;
    exp_q.push_back(e);
  endtask

  task automatic checkField(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: scoreboard empty, got count %h", tag, count);
    end else begin
      e = exp_q.pop_front();
      checkField({tag, ".count"},   count,          e.count);
      checkField({tag, ".match"},   {31'd0, match},   {31'd0, e.match});
      checkField({tag, ".wrap"},    {31'd0, wrap},    {31'd0, e.wrap});
      checkField({tag, ".running"}, {31'd0, running}, {31'd0, e.run});
      checkField({tag, ".done"},    {31'd0, done},    {31'd0, e.done});
    end
  endtask

  // One record: raise tick_in, wait for it to reach the last synchroniser
  // stage, then pulse the controls so they share the edge that counts.
  // tick_in then stays low for two periods before the next record.
  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk_in);
    tick_in    = v.tk;
    load_value = v.lv;
    compare    = v.cmp;
    dir        = v.dr;
    oneshot    = v.os;
    @(negedge clk_in);
    @(negedge clk_in);
    start = v.st;
    stop  = v.sp;
    load  = v.ld;
    pushExp(v.e_count, v.e_match, v.e_wrap, v.e_run, v.e_done);
    @(negedge clk_in);
    start = 1'b0;
    stop  = 1'b0;
    load  = 1'b0;
    checkOutput(tag);
    tick_in = 1'b0;
    @(negedge clk_in);
  endtask

  initial begin
    reset      = 1'b0;
    tick_in    = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    load       = 1'b0;
    load_value = '0;
    compare    = '0;
    dir        = 1'b0;
    oneshot    = 1'b0;
`ifdef TICK_COUNTER_CAPTURE_EN
    capture    = 1'b0;
`endif

    //        tk st sp ld  lv            cmp           dr os  count         m  w  r  d
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h5,        0, 1, 32'h0,        0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h5,        0, 1, 32'h1,        0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h5,        0, 1, 32'h2,        0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h5,        0, 1, 32'h3,        0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h5,        0, 1, 32'h4,        0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h5,        0, 1, 32'h5,        1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h5,        0, 1, 32'h5,        0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h2,        32'h4,        0, 0, 32'h2,        0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h2,        32'h4,        0, 0, 32'h2,        0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h2,        32'h4,        0, 0, 32'h3,        0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h2,        32'h4,        0, 0, 32'h2,        1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h2,        32'h4,        0, 0, 32'h3,        0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h2,        32'h4,        0, 0, 32'h2,        1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h2,        32'h4,        0, 0, 32'h3,        0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h2,        32'h4,        0, 0, 32'h2,        1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h2,        32'h4,        0, 0, 32'h2,        0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 32'h7,        32'h4,        0, 0, 32'h7,        0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h7,        32'h4,        0, 0, 32'h7,        0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h7,        32'h4,        0, 0, 32'h7,        0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h7,        32'h4,        0, 0, 32'h7,        0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hFFFFFFFE, 32'h10,       0, 0, 32'hFFFFFFFE, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'hFFFFFFFE, 32'h10,       0, 0, 32'hFFFFFFFE, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'hFFFFFFFE, 32'h10,       0, 0, 32'hFFFFFFFF, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'hFFFFFFFE, 32'h10,       0, 0, 32'h0,        0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'hFFFFFFFE, 32'h10,       0, 0, 32'h1,        0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,        32'h10,       0, 0, 32'h0,        0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'hFFFFFFF0, 1, 0, 32'hFFFFFFFF, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'hFFFFFFF0, 1, 0, 32'hFFFFFFFE, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 32'h20,       32'hFFFFFFF0, 1, 0, 32'h20,       0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h20,       32'h1F,       1, 1, 32'h1F,       1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 32'h20,       32'h100,      0, 0, 32'h1F,       0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hFFFFFFFF, 32'h0,        0, 0, 32'hFFFFFFFF, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h5,        32'h0,        0, 0, 32'h5,        1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h5,        32'h100,      0, 0, 32'h6,        0, 0, 1, 0));

    // Reset state, with tick_in held high so its edge appears at release.
    repeat (3) @(negedge clk_in);
    pushExp(32'h0, 0, 0, 0, 0);
    checkOutput("reset");
    reset = 1'b1;
    repeat (4) @(negedge clk_in);
    tick_in = 1'b0;
    repeat (2) @(negedge clk_in);
    pushExp(32'h0, 0, 0, 0, 0);
    checkOutput("stale_edge_idle");

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Latency: a tick first sampled at edge k lands at edge k+SYNC_STAGES.
    @(negedge clk_in);
    tick_in = 1'b1;
    @(negedge clk_in);
    pushExp(32'h6, 0, 0, 1, 0);
    checkOutput("lat_k");
    @(negedge clk_in);
    pushExp(32'h6, 0, 0, 1, 0);
    checkOutput("lat_k1");
    @(negedge clk_in);
    pushExp(32'h7, 0, 0, 1, 0);
    checkOutput("lat_k2");
    tick_in = 1'b0;
    @(negedge clk_in);
    pushExp(32'h7, 0, 0, 1, 0);
    checkOutput("lat_hold");

    // Asynchronous reset mid-RUN clears outputs without a clock edge.
    @(negedge clk_in);
    #2 reset = 1'b0;
    #1;
    pushExp(32'h0, 0, 0, 0, 0);
    checkOutput("async_reset");
    @(negedge clk_in);
    reset = 1'b1;
    applyStimulus(mk(1, 0, 0, 0, 32'h0, 32'h1, 0, 0, 32'h0, 0, 0, 0, 0), "post_reset_tick");

`ifdef TICK_COUNTER_CAPTURE_EN
    // Capture coincident with a tick sees the pre-tick count.
    applyStimulus(mk(0, 1, 0, 1, 32'h9, 32'h100, 0, 0, 32'h9, 0, 0, 1, 0), "cap_load");
    @(negedge clk_in);
    tick_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    capture = 1'b1;
    pushExp(32'hA, 0, 0, 1, 0);
    @(negedge clk_in);
    capture = 1'b0;
    checkOutput("cap_tick");
    checkField("capture_value", capture_value, 32'h9);
    tick_in = 1'b0;
    @(negedge clk_in);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
